// File: rtl/rw_port_ram_be_pkg.sv
// Shared constants and types for the byte-enable dual-port RAM.
// Read-during-write and latency encodings match the RDW_MODE / READ_LATENCY parameters.
package rw_port_ram_be_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;
   localparam int LAT_1   = 1;
   localparam int LAT_2   = 2;

   typedef enum logic {
      CLR_ST_CLEAR = 1'b0,
      CLR_ST_RUN   = 1'b1
   } clr_state_t;

   // Overlay the lanes flagged in sel with the matching lanes of upd.
   function automatic logic [63:0] lane_merge(
      input logic [63:0] base,
      input logic [63:0] upd,
      input logic [7:0]  sel,
      input int          lane_width,
      input int          lanes
   );
      logic [63:0] res;
      res = base;
      for (int i = 0; i < lanes; i++) begin
         for (int b = 0; b < lane_width; b++) begin
            if (sel[i]) begin
               res[i*lane_width+b] = upd[i*lane_width+b];
            end else begin
               res[i*lane_width+b] = base[i*lane_width+b];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rw_port_ram_be_lane.sv
// One LANE_WIDTH x DEPTH column of the RAM with its own write enable.
// Synchronous read register returns the pre-write word on a same-address collision.
module rw_port_ram_lane
   import rw_port_ram_be_pkg::*;
#(
   parameter int LANE_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr_w,
   input  logic [LANE_WIDTH-1:0] data_in,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr_r,
   output logic [LANE_WIDTH-1:0] data_out
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [LANE_WIDTH-1:0] mem_r [DEPTH];
   logic [LANE_WIDTH-1:0] rd_r;

   // Array write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr_w] <= data_in;
      end
   end

   // RAM output register, only loaded by a read so the value holds otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_r <= '0;
      end else if (re) begin
         rd_r <= mem_r[addr_r];
      end
   end

   assign data_out = rd_r;

endmodule

// File: rtl/rw_port_ram_be.sv
// Simple dual-port RAM with lane write enables, read valid, 1/2-cycle latency and RDW policy.
// Optional power-up clear sweep enabled by defining RW_PORT_RAM_CLEAR_EN.
module rw_port_ram_be
   import rw_port_ram_be_pkg::*;
#(
   parameter int LANE_WIDTH   = 8,
   parameter int LANES        = 4,
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_WIDTH-1:0]       addr_w,
   input  logic [LANE_WIDTH*LANES-1:0] data_in,
   input  logic                        we,
   input  logic [LANES-1:0]            be,
   input  logic [ADDR_WIDTH-1:0]       addr_r,
   input  logic                        re,
   output logic [LANE_WIDTH*LANES-1:0] data_out,
   output logic                        valid_out,
   output logic                        busy
);

   localparam int DATA_WIDTH = LANE_WIDTH * LANES;

   logic [ADDR_WIDTH-1:0] wr_addr_s;
   logic [DATA_WIDTH-1:0] wr_data_s;
   logic [LANES-1:0]      wr_en_s;
   logic                  rd_en_s;
   logic [DATA_WIDTH-1:0] lane_q_s;
   logic [DATA_WIDTH-1:0] word_s;
   logic [LANES-1:0]      fwd_sel_s;
   logic [DATA_WIDTH-1:0] fwd_data_s;
   logic                  v1_r;

`ifdef RW_PORT_RAM_CLEAR_EN
   clr_state_t            state_r;
   clr_state_t            state_nx_s;
   logic [ADDR_WIDTH-1:0] clr_addr_r;
   logic [ADDR_WIDTH-1:0] clr_addr_nx_s;
   logic                  busy_r;

   // Clear FSM state, sweep address and busy flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= CLR_ST_CLEAR;
         clr_addr_r <= '0;
         busy_r     <= 1'b1;
      end else begin
         state_r    <= state_nx_s;
         clr_addr_r <= clr_addr_nx_s;
         busy_r     <= (state_nx_s == CLR_ST_CLEAR);
      end
   end

   // Sweep every address once, then stay in RUN until the next reset.
   always_comb begin
      state_nx_s    = state_r;
      clr_addr_nx_s = clr_addr_r;
      case (state_r)
         CLR_ST_CLEAR: begin
            clr_addr_nx_s = clr_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (clr_addr_r == {ADDR_WIDTH{1'b1}}) begin
               state_nx_s = CLR_ST_RUN;
            end else begin
               state_nx_s = CLR_ST_CLEAR;
            end
         end
         CLR_ST_RUN: begin
            state_nx_s = CLR_ST_RUN;
         end
         default: begin
            state_nx_s    = CLR_ST_CLEAR;
            clr_addr_nx_s = '0;
         end
      endcase
   end

   assign busy = busy_r;
`else
   assign busy = 1'b0;
`endif

   // Port steering: the clear sweep owns the write port and blocks reads.
   always_comb begin
      wr_addr_s = addr_w;
      wr_data_s = data_in;
      wr_en_s   = {LANES{we}} & be;
      rd_en_s   = re;
`ifdef RW_PORT_RAM_CLEAR_EN
      if (busy_r) begin
         wr_addr_s = clr_addr_r;
         wr_data_s = '0;
         wr_en_s   = {LANES{1'b1}};
         rd_en_s   = 1'b0;
      end else begin
         wr_addr_s = addr_w;
         wr_data_s = data_in;
         wr_en_s   = {LANES{we}} & be;
         rd_en_s   = re;
      end
`endif
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      rw_port_ram_lane #(
         .LANE_WIDTH (LANE_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .we       (wr_en_s[g]),
         .addr_w   (wr_addr_s),
         .data_in  (wr_data_s[g*LANE_WIDTH +: LANE_WIDTH]),
         .re       (rd_en_s),
         .addr_r   (addr_r),
         .data_out (lane_q_s[g*LANE_WIDTH +: LANE_WIDTH])
      );
   end

   if (RDW_MODE == RDW_NEW) begin : g_fwd
      logic [LANES-1:0]      fwd_sel_r;
      logic [DATA_WIDTH-1:0] fwd_data_r;

      // Capture which lanes collide with a same-edge write; the lane RAM still returns old data.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            fwd_sel_r  <= '0;
            fwd_data_r <= '0;
         end else if (rd_en_s) begin
            fwd_sel_r  <= (we && (addr_w == addr_r)) ? be : '0;
            fwd_data_r <= data_in;
         end
      end

      assign fwd_sel_s  = fwd_sel_r;
      assign fwd_data_s = fwd_data_r;
   end else begin : g_nofwd
      assign fwd_sel_s  = '0;
      assign fwd_data_s = '0;
   end

   // Forwarding mux after the RAM register keeps the array inferable as block RAM.
   always_comb begin
      word_s = lane_q_s;
      for (int i = 0; i < LANES; i++) begin
         if (fwd_sel_s[i]) begin
            word_s[i*LANE_WIDTH +: LANE_WIDTH] = fwd_data_s[i*LANE_WIDTH +: LANE_WIDTH];
         end else begin
            word_s[i*LANE_WIDTH +: LANE_WIDTH] = lane_q_s[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   // First valid stage, aligned with the RAM output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_r <= 1'b0;
      end else begin
         v1_r <= rd_en_s;
      end
   end

   if (READ_LATENCY == LAT_2) begin : g_lat2
      logic [DATA_WIDTH-1:0] data2_r;
      logic                  v2_r;

      // Extra output pipeline stage; data only advances with a fresh read.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data2_r <= '0;
            v2_r    <= 1'b0;
         end else begin
            v2_r <= v1_r;
            if (v1_r) begin
               data2_r <= word_s;
            end
         end
      end

      assign data_out  = data2_r;
      assign valid_out = v2_r;
   end else begin : g_lat1
      assign data_out  = word_s;
      assign valid_out = v1_r;
   end

endmodule

// File: tb/tb_rw_port_ram_be.sv
// Directed bench: dut_a = defaults (old-data RDW, latency 1), dut_b = new-data RDW, latency 2, 16 words.
// Clear-sweep checks are compiled when RW_PORT_RAM_CLEAR_EN is defined.
module tb_rw_port_ram_be;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] addr_w = 12'h000;
   logic [31:0] data_in = 32'h0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [11:0] addr_r = 12'h000;
   logic        re = 1'b0;

   logic [31:0] data_a, data_b;
   logic        valid_a, valid_b, busy_a, busy_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] v4 [4];

`ifdef RW_PORT_RAM_CLEAR_EN
   localparam logic BUSY_RST = 1'b1;
`else
   localparam logic BUSY_RST = 1'b0;
`endif

   always #5 clk = ~clk;

   rw_port_ram_be dut_a (
      .clk(clk), .reset(reset), .addr_w(addr_w), .data_in(data_in), .we(we), .be(be),
      .addr_r(addr_r), .re(re), .data_out(data_a), .valid_out(valid_a), .busy(busy_a)
   );

   rw_port_ram_be #(.ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1)) dut_b (
      .clk(clk), .reset(reset), .addr_w(addr_w[3:0]), .data_in(data_in), .we(we), .be(be),
      .addr_r(addr_r[3:0]), .re(re), .data_out(data_b), .valid_out(valid_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      v4[0] = 32'h1111_0000;
      v4[1] = 32'h2222_0101;
      v4[2] = 32'h3333_0202;
      v4[3] = 32'h4444_0303;

      #2 reset = 1'b1;
      tick(); tick();
      chk("rst_data_a", data_a, 32'h0);
      chk("rst_valid_a", {31'h0, valid_a}, 32'h0);
      chk("rst_data_b", data_b, 32'h0);
      chk("rst_valid_b", {31'h0, valid_b}, 32'h0);
      chk("rst_busy_b", {31'h0, busy_b}, {31'h0, BUSY_RST});
      reset = 1'b0;

`ifdef RW_PORT_RAM_CLEAR_EN
      // reset again in the middle of the sweep
      for (int k = 1; k <= 7; k++) tick();
      reset = 1'b1;
      tick();
      chk("midsweep_busy", {31'h0, busy_b}, 32'h1);
      reset = 1'b0;
      re = 1'b1;
      addr_r = 12'h000;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("sweep_busy_%0d", k), {31'h0, busy_b}, (k < 16) ? 32'h1 : 32'h0);
         chk($sformatf("sweep_valid_%0d", k), {31'h0, valid_b}, 32'h0);
      end
      re = 1'b0;
      tick();
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            re = 1'b1;
            addr_r = 12'(i);
         end else begin
            re = 1'b0;
         end
         tick();
         if (i >= 1 && i <= 16) begin
            chk($sformatf("clr_valid_%0d", i - 1), {31'h0, valid_b}, 32'h1);
            chk($sformatf("clr_data_%0d", i - 1), data_b, 32'h0);
         end
      end
      for (int k = 0; k < 5000 && busy_a; k++) tick();
      chk("sweep_a_done", {31'h0, busy_a}, 32'h0);
`else
      tick();
      chk("busy_a_idle", {31'h0, busy_a}, 32'h0);
      chk("busy_b_idle", {31'h0, busy_b}, 32'h0);
`endif

      // T1: full-word write then read
      we = 1'b1; addr_w = 12'd5; data_in = 32'hA5A5_A5A5; be = 4'hF;
      tick();
      we = 1'b0; re = 1'b1; addr_r = 12'd5;
      tick();
      re = 1'b0;
      chk("t1_valid_a", {31'h0, valid_a}, 32'h1);
      chk("t1_data_a", data_a, 32'hA5A5_A5A5);
      chk("t1_valid_b_early", {31'h0, valid_b}, 32'h0);
      tick();
      chk("t1_valid_a_pulse", {31'h0, valid_a}, 32'h0);
      chk("t1_data_a_hold", data_a, 32'hA5A5_A5A5);
      chk("t1_valid_b", {31'h0, valid_b}, 32'h1);
      chk("t1_data_b", data_b, 32'hA5A5_A5A5);

      // T2: partial-lane write
      we = 1'b1; addr_w = 12'd5; data_in = 32'h1122_3344; be = 4'b0101;
      tick();
      we = 1'b0; re = 1'b1; addr_r = 12'd5;
      tick();
      re = 1'b0;
      chk("t2_data_a", data_a, 32'hA522_A544);
      tick();
      chk("t2_data_b", data_b, 32'hA522_A544);
      tick();

      // T3: same-address read during write
      we = 1'b1; addr_w = 12'd9; data_in = 32'h0; be = 4'hF;
      tick();
      data_in = 32'hFFFF_FFFF; re = 1'b1; addr_r = 12'd9;
      tick();
      chk("t3_old_a", data_a, 32'h0);
      chk("t3_old_valid_a", {31'h0, valid_a}, 32'h1);
      we = 1'b0;
      tick();
      chk("t3_next_a", data_a, 32'hFFFF_FFFF);
      chk("t3_new_b", data_b, 32'hFFFF_FFFF);
      we = 1'b1; data_in = 32'h1234_5678; be = 4'b0011;
      tick();
      chk("t3p_old_a", data_a, 32'hFFFF_FFFF);
      chk("t3_next_b", data_b, 32'hFFFF_FFFF);
      we = 1'b0;
      tick();
      chk("t3p_next_a", data_a, 32'hFFFF_5678);
      chk("t3p_fwd_b", data_b, 32'hFFFF_5678);
      re = 1'b0;
      tick();
      chk("t3_idle_valid_a", {31'h0, valid_a}, 32'h0);
      chk("t3_idle_data_a", data_a, 32'hFFFF_5678);
      chk("t3p_next_b", data_b, 32'hFFFF_5678);
      tick();
      chk("t3_idle_valid_b", {31'h0, valid_b}, 32'h0);

      // T4: back-to-back reads
      for (int i = 0; i < 4; i++) begin
         we = 1'b1; be = 4'hF; addr_w = 12'(i); data_in = v4[i];
         tick();
      end
      we = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            re = 1'b1;
            addr_r = 12'(i);
         end else begin
            re = 1'b0;
         end
         tick();
         if (i < 4) begin
            chk($sformatf("t4_valid_a_%0d", i), {31'h0, valid_a}, 32'h1);
            chk($sformatf("t4_data_a_%0d", i), data_a, v4[i]);
         end else begin
            chk($sformatf("t4_valid_a_%0d", i), {31'h0, valid_a}, 32'h0);
         end
         if (i >= 1 && i <= 4) begin
            chk($sformatf("t4_valid_b_%0d", i), {31'h0, valid_b}, 32'h1);
            chk($sformatf("t4_data_b_%0d", i), data_b, v4[i-1]);
         end else begin
            chk($sformatf("t4_valid_b_%0d", i), {31'h0, valid_b}, 32'h0);
         end
      end
      chk("t4_hold_b", data_b, v4[3]);

      // independent read and write on different addresses
      we = 1'b1; be = 4'hF; addr_w = 12'd0; data_in = 32'hCAFE_F00D; re = 1'b1; addr_r = 12'd1;
      tick();
      we = 1'b0; addr_r = 12'd0;
      chk("indep_a", data_a, v4[1]);
      tick();
      re = 1'b0;
      chk("indep_b", data_b, v4[1]);
      chk("indep_w_a", data_a, 32'hCAFE_F00D);
      tick();
      chk("indep_w_b", data_b, 32'hCAFE_F00D);

      // top address, and we with no lanes enabled
      we = 1'b1; be = 4'hF; addr_w = 12'hFFF; data_in = 32'hDEAD_BEEF;
      tick();
      be = 4'h0; data_in = 32'h0;
      tick();
      we = 1'b0; re = 1'b1; addr_r = 12'hFFF;
      tick();
      re = 1'b0;
      chk("top_be0_a", data_a, 32'hDEAD_BEEF);
      tick();
      chk("top_be0_b", data_b, 32'hDEAD_BEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
